// File: rtl/ysyx_22050550_ifetch.sv
// Instruction-fetch stage: one outstanding memory read per fetch_pc, instruction handed to ID
// over valid/ready, wrong-path work discarded when ID redirects.
`timescale 1ns/1ps
module ysyx_22050550_ifetch #(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h80000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ready,
  input  logic              id_redirect,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              drop_q, drop_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              misalign_q, misalign_d;
  logic              misaligned;
  logic              req_fire;

  assign misaligned = fetch_pc_q[1:0] != 2'b00;
  assign req_fire   = mem_req_valid && mem_req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Redirect takes priority over everything; a misaligned PC never reaches memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (id_redirect) begin
          if (req_fire) state_d = S_WAIT;
        end else if (misaligned) begin
          state_d = S_HOLD;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) state_d = (drop_q || id_redirect) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (id_redirect || inst_ready) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = (state_q == S_REQ) && !misaligned;
    mem_req_addr  = mem_req_valid ? {fetch_pc_q[ADDR_W-1:3], 3'b000} : '0;
    pc_ready      = (state_q == S_REQ) && !id_redirect && (misaligned || mem_req_ready);
    inst_valid    = (state_q == S_HOLD);
    inst          = inst_q;
    inst_pc       = inst_pc_q;
    inst_misalign = misalign_q;
  end

  // fetch_pc follows pc_in on every entry into REQ and on a redirect while still requesting.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = misalign_q;
    if (state_d == S_REQ && (state_q != S_REQ || id_redirect)) fetch_pc_d = pc_in;
    if (state_q == S_REQ && id_redirect && req_fire) drop_d = 1'b1;
    if (state_q == S_WAIT) begin
      if (mem_rsp_valid)    drop_d = 1'b0;
      else if (id_redirect) drop_d = 1'b1;
    end
    if (state_q == S_REQ && state_d == S_HOLD) begin
      inst_d     = 32'h0;
      inst_pc_d  = fetch_pc_q;
      misalign_d = 1'b1;
    end
    if (state_q == S_WAIT && state_d == S_HOLD) begin
      inst_d     = fetch_pc_q[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
      inst_pc_d  = fetch_pc_q;
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      inst_q     <= 32'h0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_ifetch.sv
// Scoreboard bench for the fetch stage: directed PC/redirect/reset scenarios against a
// small memory model; request addresses and delivered instructions are checked from queues.
`timescale 1ns/1ps
module tb_ysyx_22050550_ifetch;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        mis;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [63:0] pc_in;
  logic        pc_ready;
  logic        id_redirect;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_misalign;

  int          checks = 0;
  int          errors = 0;
  int          pcReadyCount = 0;
  int          rspDelay = 0;
  exp_t        expQ[$];
  logic [63:0] reqQ[$];

  ysyx_22050550_ifetch dut (
    .clock         (clock),
    .reset         (reset),
    .pc_in         (pc_in),
    .pc_ready      (pc_ready),
    .id_redirect   (id_redirect),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_misalign (inst_misalign)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] memData(input logic [63:0] addr);
    case (addr)
      64'h80000000: return 64'h00100093_00000513;
      64'h80000100: return 64'h00208113_00300193;
      64'h80000300: return 64'h00400213_00500293;
      default:      return 64'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitInstValid(input int bound);
    int i = 0;
    while (!inst_valid && i < bound) begin
      step(1);
      i++;
    end
    checkOutput("instValidWait", inst_valid, 1);
  endtask

  // Wait for the instruction, check pc_ready history, then accept it with the next PC ready.
  task automatic applyStimulus(input logic [63:0] nextPc, input int expPcReady);
    waitInstValid(20);
    checkOutput("pcReadyCount", pcReadyCount, expPcReady);
    pc_in      = nextPc;
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_memReqValid"}, mem_req_valid, 0);
    checkOutput({tag, "_memReqAddr"}, mem_req_addr, 0);
    checkOutput({tag, "_pcReady"}, pc_ready, 0);
    checkOutput({tag, "_instValid"}, inst_valid, 0);
    checkOutput({tag, "_inst"}, inst, 0);
    checkOutput({tag, "_instPc"}, inst_pc, 0);
    checkOutput({tag, "_instMisalign"}, inst_misalign, 0);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (pc_ready) pcReadyCount++;
    end
  end

  // Memory model: checks each accepted address, answers 1+rspDelay cycles later.
  initial begin
    logic [63:0] addr;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'h0;
    forever begin
      @(negedge clock);
      if (reset && mem_req_valid && mem_req_ready) begin
        addr = mem_req_addr;
        if (reqQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL reqAddr actual=%h required=none", addr);
        end else begin
          checkOutput("reqAddr", addr, reqQ.pop_front());
        end
        @(posedge clock);
        repeat (rspDelay) @(posedge clock);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = memData(addr);
        @(posedge clock);
        #1;
        mem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: every accepted instruction must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && inst_valid && inst_ready && !id_redirect) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedInst actual=%h@%h required=none", inst, inst_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("inst", inst, e.inst);
          checkOutput("instPc", inst_pc, e.pc);
          checkOutput("instMisalign", inst_misalign, e.mis);
        end
      end
    end
  end

  initial begin
    reset         = 1'b0;
    pc_in         = 64'h0;
    id_redirect   = 1'b0;
    mem_req_ready = 1'b0;
    inst_ready    = 1'b0;
    step(2);
    checkAllZero("reset");

    // Lower word fetch, then hold under back-pressure.
    reqQ.push_back(64'h80000000);
    expQ.push_back('{32'h00000513, 64'h80000000, 1'b0});
    pc_in         = 64'h80000000;
    mem_req_ready = 1'b1;
    reset         = 1'b1;
    waitInstValid(20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpInst", inst, 64'h00000513);
      checkOutput("bpInstPc", inst_pc, 64'h80000000);
      checkOutput("bpMemReqValid", mem_req_valid, 0);
      checkOutput("bpPcReady", pc_ready, 0);
      checkOutput("bpInstValid", inst_valid, 1);
      step(1);
    end
    applyStimulus(64'h80000004, 1);

    // Upper word selected by pc[2].
    reqQ.push_back(64'h80000000);
    expQ.push_back('{32'h00100093, 64'h80000004, 1'b0});
    applyStimulus(64'h80000008, 2);

    // Redirect while waiting: late response is dropped, refetch from the new PC.
    reqQ.push_back(64'h80000008);
    reqQ.push_back(64'h80000100);
    expQ.push_back('{32'h00300193, 64'h80000100, 1'b0});
    rspDelay = 3;
    step(1);
    id_redirect = 1'b1;
    pc_in       = 64'h80000100;
    rspDelay    = 0;
    step(1);
    id_redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkOutput("dropNoInstValid", inst_valid, 0);
    end
    applyStimulus(64'h80000200, 4);

    // Redirect coincident with the request handshake.
    reqQ.push_back(64'h80000200);
    reqQ.push_back(64'h80000300);
    expQ.push_back('{32'h00500293, 64'h80000300, 1'b0});
    id_redirect = 1'b1;
    pc_in       = 64'h80000300;
    #1;
    checkOutput("redirPcReady", pc_ready, 0);
    checkOutput("redirMemReqValid", mem_req_valid, 1);
    step(1);
    id_redirect = 1'b0;
    applyStimulus(64'h80000002, 5);

    // Misaligned PC: no memory request, zero instruction flagged.
    expQ.push_back('{32'h0, 64'h80000002, 1'b1});
    #1;
    checkOutput("misMemReqValid", mem_req_valid, 0);
    checkOutput("misPcReady", pc_ready, 1);
    rspDelay = 1;
    applyStimulus(64'h80000400, 6);

    // Reset while waiting; the in-flight response lands during reset.
    reqQ.push_back(64'h80000400);
    step(1);
    reset = 1'b0;
    #1;
    checkAllZero("midReset");
    step(3);
    checkOutput("postRspInstValid", inst_valid, 0);
    checkOutput("postRspMemReqValid", mem_req_valid, 0);
    reqQ.push_back(64'h80000000);
    expQ.push_back('{32'h00000513, 64'h80000000, 1'b0});
    rspDelay = 0;
    pc_in    = 64'h80000000;
    reset    = 1'b1;
    waitInstValid(20);
    mem_req_ready = 1'b0;
    applyStimulus(64'h80000010, 8);

    step(4);
    checkOutput("stallMemReqValid", mem_req_valid, 1);
    checkOutput("stallMemReqAddr", mem_req_addr, 64'h80000010);
    checkOutput("finalPcReadyCount", pcReadyCount, 8);
    checkOutput("expQEmpty", expQ.size(), 0);
    checkOutput("reqQEmpty", reqQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_ifetch.md
Name: ysyx_22050550_ifetch

Overview:
Instruction-fetch stage that consumes the next-PC stream from the PC register and produces fetched instructions to the ID stage. It issues one outstanding read to instruction memory over a valid/ready request channel with a valid-only response. It returns a 32-bit instruction with its PC over a valid/ready handshake. Its advance strobe tells the PC register when to step PC+4, and it discards wrong-path work when ID redirects (jal/jalr/branch/ecall/mret).

Parameters:
ADDR_W, 64, width of PC and memory address
DATA_W, 64, width of memory response data; instruction selected by addr[2]
RESET_PC, 64'h80000000, reset value of internal fetch_pc register

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low (asserted when 0); deassertion sync'd externally
pc_in  input  ADDR_W  next PC from PC register (combinational npc, already redirect-corrected)
pc_ready  output  1  one-cycle strobe: PC register advances to pc_in+4
id_redirect  input  1  ID taken control transfer (jal type != 0 and ID valid); flush wrong path
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  request address = fetch_pc with low 3 bits cleared
mem_rsp_valid  input  1  read data valid, exactly one per accepted request, >=1 cycle after accept
mem_rsp_data  input  DATA_W  read data
inst_valid  output  1  instruction to ID valid
inst_ready  input  1  ID accepts instruction
inst  output  32  instruction word
inst_pc  output  ADDR_W  PC of inst
inst_misalign  output  1  qualifies inst_valid: fetch_pc[1:0] != 0, inst = 0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, fetch_pc=RESET_PC, drop=0; all outputs 0.
- States: IDLE, REQ, WAIT, HOLD.
- Entering REQ: fetch_pc <= pc_in, sampled at the transition edge.
- IDLE: -> REQ unconditionally next cycle.
- REQ: mem_req_valid=1 unless fetch_pc[1:0]!=0.
  - On handshake (valid&ready): pc_ready=1 that cycle, -> WAIT.
  - Misaligned fetch_pc: no request. Load inst=0, inst_pc=fetch_pc, inst_misalign=1, pc_ready=1, -> HOLD.
  - id_redirect without handshake: reload fetch_pc<=pc_in, stay REQ. Address may change before handshake; memory samples only on handshake.
  - id_redirect with handshake in same cycle: pc_ready=0, drop<=1, -> WAIT.
- WAIT: mem_req_valid=0.
  - On mem_rsp_valid with drop=0 and no id_redirect: inst <= fetch_pc[2] ? data[63:32] : data[31:0]; inst_pc<=fetch_pc; inst_misalign<=0; -> HOLD.
  - On mem_rsp_valid with drop=1 or id_redirect: discard, drop<=0, -> REQ.
  - id_redirect without response: drop<=1, stay WAIT.
- HOLD: inst_valid=1; inst, inst_pc, inst_misalign stable until handshake.
  - inst_ready=1 and no id_redirect: -> REQ.
  - id_redirect (regardless of inst_ready): inst_valid deasserts next cycle, no transfer counted, -> REQ.
- pc_ready asserts only in REQ, never while id_redirect=1. It is never asserted twice for one fetch_pc.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory.
- Exactly one request outstanding. mem_rsp_valid outside WAIT is a protocol error: ignored.
- Reset mid-operation: immediate return to IDLE. Any response for a pre-reset request arriving after reset is ignored (state != WAIT).

Test Plan:
- Reset release, pc_in=0x80000000, mem ready=1, rsp 1 cycle later with data=0x00100093_00000513: mem_req_addr=0x80000000. pc_ready pulses once. Then inst=0x00000513, inst_pc=0x80000000, inst_valid held until inst_ready.
- pc_in=0x80000004, same data: inst=0x00100093 (upper word), inst_pc=0x80000004.
- Back-pressure: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, mem_req_valid=0, pc_ready=0 throughout.
- id_redirect in WAIT (pc_in=0x80000100), response arrives 3 cycles later -> response dropped, no inst_valid. Next request addr=0x80000100.
- id_redirect coincident with request handshake -> pc_ready=0, that response dropped, refetch from pc_in.
- pc_in=0x80000002 -> no mem_req_valid. inst_valid=1, inst_misalign=1, inst=0, inst_pc=0x80000002.
- reset asserted in WAIT, rsp_valid arrives during/after reset -> all outputs 0, no inst_valid, fetch restarts at pc_in.
